serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one mux-based full adder cell, one bit per cycle,
// LSB first, operands in and result out over valid/ready handshakes.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic p;

    assign p     = a ^ b;
    assign sum   = p ? ~c_in : c_in;
    assign c_out = p ? c_in : a;

endmodule

module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_sum;
    logic          fa_cout;

    full_adder fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= c_in;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at sum_sh[0] after W shifts
                    sum_sh <= {fa_sum, sum_sh[W-1:1]};
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == CW'(W - 1))
                        state <= DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign c_out     = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl, W=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then measure busy cycles and latency to out_valid.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] es, input logic ec);
        int n;
        int bc;
        n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        c_in = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        bc = 0;
        while (!out_valid && n < 20) begin
            if (busy) bc++;
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    endtask

    logic [7:0] hs;
    logic       hc;
    int         nres;
    int         nacc;
    logic       prev_busy;
    logic [7:0] op_a [3];
    logic [7:0] op_b [3];
    logic       op_c [3];
    logic [8:0] ref_r;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        reset_n = 1'b1;
        step();

        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        step();
        chk("add5a3c_idle", 32'(in_ready), 32'd1);
        run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        step();
        run_op("ff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        step();
        run_op("ffffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        step();

        // Backpressure in DONE
        out_ready = 1'b0;
        run_op("bp", 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1);
        hs = sum;
        hc = c_out;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'(hs));
            chk("bp_c_out", 32'(c_out), 32'(hc));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Input change during RUN
        a = 8'h12;
        b = 8'h34;
        c_in = 1'b0;
        in_valid = 1'b1;
        step();
        a = 8'hFF;
        b = 8'hFF;
        nres = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 5) in_valid = 1'b0;
            if (out_valid) begin
                nres++;
                chk("runchg_sum", 32'(sum), 32'h46);
                chk("runchg_c_out", 32'(c_out), 32'd0);
            end
            step();
        end
        chk("runchg_results", 32'(nres), 32'd1);

        // Reset in RUN cycle 4
        a = 8'h77;
        b = 8'h11;
        c_in = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_c_out", 32'(c_out), 32'd0);
        #3;
        reset_n = 1'b1;
        nres = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) nres++;
        end
        chk("midrst_no_result", 32'(nres), 32'd0);
        run_op("midrst_0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        step();

        // Back-to-back with in_valid and out_ready tied high
        op_a[0] = 8'h5A; op_b[0] = 8'hA5; op_c[0] = 1'b1;
        op_a[1] = 8'h33; op_b[1] = 8'h44; op_c[1] = 1'b0;
        op_a[2] = 8'hC8; op_b[2] = 8'h64; op_c[2] = 1'b1;
        chk("b2b_idle", 32'(in_ready), 32'd1);
        a = op_a[0];
        b = op_b[0];
        c_in = op_c[0];
        in_valid = 1'b1;
        step();
        nacc = 1;
        a = op_a[1];
        b = op_b[1];
        c_in = op_c[1];
        prev_busy = busy;
        nres = 0;
        for (int e = 1; e <= 34; e++) begin
            step();
            if (busy && !prev_busy) begin
                nacc++;
                if (nacc < 3) begin
                    a = op_a[nacc];
                    b = op_b[nacc];
                    c_in = op_c[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            prev_busy = busy;
            if (out_valid && nres < 3) begin
                ref_r = 9'(op_a[nres]) + 9'(op_b[nres]) + 9'(op_c[nres]);
                chk("b2b_edge", 32'(e), 32'(8 + 10 * nres));
                chk("b2b_sum", 32'(sum), 32'(ref_r[7:0]));
                chk("b2b_c_out", 32'(c_out), 32'(ref_r[8]));
                nres++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_results", 32'(nres), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
